// File: rtl/usb_packet_rx.sv
// USB full-packet receiver: line synchroniser, bit-timing recovery, NRZI decode,
// bit unstuffing, SYNC/PID/body extraction and error classification.
module usb_packet_rx #(
    parameter int CLKS_PER_BIT   = 8,
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 d_plus,
    input  logic                                 d_minus,
    input  logic                                 r_enable,
    output logic                                 pkt_valid,
    output logic                                 rcv_busy,
    output logic [7:0]                           rcv_sync,
    output logic [7:0]                           rcv_pid,
    output logic [10:0]                          rcv_token,
    output logic [4:0]                           rcv_crc5,
    output logic [15:0]                          rcv_crc16,
    output logic [8*MAX_DATA_BYTES-1:0]          rcv_data,
    output logic [$clog2(MAX_DATA_BYTES+1)-1:0]  rcv_byte_cnt,
    output logic [2:0]                           rcv_error,
    output logic                                 rcv_overrun
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TICK_SAMP = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_SYNC   = 3'd1;
    localparam logic [2:0] ERR_PID    = 3'd2;
    localparam logic [2:0] ERR_STUFF  = 3'd3;
    localparam logic [2:0] ERR_LENGTH = 3'd4;
    localparam logic [2:0] ERR_OVFL   = 3'd5;
    localparam logic [2:0] ERR_UNSUP  = 3'd6;

    localparam logic [1:0] T_TOKEN = 2'b01;
    localparam logic [1:0] T_HAND  = 2'b10;
    localparam logic [1:0] T_DATA  = 2'b11;

    typedef enum logic [2:0] {IDLE, SYNC, PID, BODY, EOP, HOLD} state_t;

    state_t state;

    logic dp_s1, dp_s2, dm_s1, dm_s2, dp_q, dm_q;
    logic [CW-1:0] tick_cnt;
    logic          skip;
    logic          last_lvl;
    logic [2:0]    ones_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [15:0]   dly;
    logic [15:0]   body_bits;
    logic [1:0]    ptype;

    logic line_j, line_k, line_se0, prev_j, prev_k, prev_se0;
    logic dp_edge, sample, start_seen, eop_end;
    logic nrzi_bit, stuff_slot, byte_done, no_err;
    logic [7:0]  byte_next;
    logic [12:0] body_bytes, pay_idx;

    // SE1 is not J or K, so it falls into the SE0 class.
    assign line_j   = dp_s2 & ~dm_s2;
    assign line_k   = ~dp_s2 & dm_s2;
    assign line_se0 = ~(line_j | line_k);
    assign prev_j   = dp_q & ~dm_q;
    assign prev_k   = ~dp_q & dm_q;
    assign prev_se0 = ~(prev_j | prev_k);

    assign dp_edge    = dp_s2 ^ dp_q;
    assign sample     = (tick_cnt == TICK_SAMP);
    assign start_seen = prev_j & line_k;
    assign eop_end    = prev_se0 & line_j;

    assign nrzi_bit   = (dp_s2 == last_lvl);
    assign stuff_slot = (ones_cnt == 3'd6);
    assign byte_next  = {nrzi_bit, shreg[7:1]};
    assign byte_done  = (body_bits[2:0] == 3'd7);
    assign body_bytes = body_bits[15:3];
    assign pay_idx    = body_bytes - 13'd2;
    assign no_err     = (rcv_error == ERR_NONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_s1    <= 1'b0;
            dp_s2    <= 1'b0;
            dm_s1    <= 1'b0;
            dm_s2    <= 1'b0;
            dp_q     <= 1'b0;
            dm_q     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            dp_s1 <= d_plus;
            dp_s2 <= dp_s1;
            dm_s1 <= d_minus;
            dm_s2 <= dm_s1;
            dp_q  <= dp_s2;
            dm_q  <= dm_s2;
            if (dp_edge || tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end
        end
    end

    // Handshake: pkt_valid rises when a packet completes and the result registers
    // stay frozen until a one-cycle r_enable is seen while pkt_valid is high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            skip         <= 1'b0;
            last_lvl     <= 1'b0;
            ones_cnt     <= 3'd0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'd0;
            dly          <= 16'd0;
            body_bits    <= 16'd0;
            ptype        <= 2'b00;
            pkt_valid    <= 1'b0;
            rcv_busy     <= 1'b0;
            rcv_sync     <= 8'd0;
            rcv_pid      <= 8'd0;
            rcv_token    <= 11'd0;
            rcv_crc5     <= 5'd0;
            rcv_crc16    <= 16'd0;
            rcv_data     <= '0;
            rcv_byte_cnt <= '0;
            rcv_error    <= ERR_NONE;
            rcv_overrun  <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (state == HOLD && r_enable) begin
                        state       <= IDLE;
                        pkt_valid   <= 1'b0;
                        rcv_overrun <= 1'b0;
                    end else if (skip) begin
                        if (eop_end) skip <= 1'b0;
                    end else if (start_seen) begin
                        if (pkt_valid) begin
                            rcv_overrun <= 1'b1;
                            skip        <= 1'b1;
                        end else begin
                            state        <= SYNC;
                            rcv_busy     <= 1'b1;
                            last_lvl     <= 1'b1;
                            ones_cnt     <= 3'd0;
                            bit_cnt      <= 3'd0;
                            body_bits    <= 16'd0;
                            ptype        <= 2'b00;
                            dly          <= 16'd0;
                            rcv_sync     <= 8'd0;
                            rcv_pid      <= 8'd0;
                            rcv_token    <= 11'd0;
                            rcv_crc5     <= 5'd0;
                            rcv_crc16    <= 16'd0;
                            rcv_data     <= '0;
                            rcv_byte_cnt <= '0;
                            rcv_error    <= ERR_NONE;
                        end
                    end
                end
                SYNC, PID, BODY: begin
                    if (sample) begin
                        if (line_se0) begin
                            state <= EOP;
                            if (state != BODY) begin
                                if (no_err) rcv_error <= ERR_LENGTH;
                            end else begin
                                case (ptype)
                                    T_TOKEN: begin
                                        rcv_token <= dly[10:0];
                                        rcv_crc5  <= dly[15:11];
                                        if (body_bits != 16'd16 && no_err) rcv_error <= ERR_LENGTH;
                                    end
                                    T_HAND: begin
                                        if (body_bits != 16'd0 && no_err) rcv_error <= ERR_LENGTH;
                                    end
                                    T_DATA: begin
                                        rcv_crc16 <= dly;
                                        if ((body_bits[2:0] != 3'd0 || body_bits < 16'd16) && no_err)
                                            rcv_error <= ERR_LENGTH;
                                    end
                                    default: ;
                                endcase
                            end
                        end else begin
                            last_lvl <= dp_s2;
                            if (stuff_slot) begin
                                ones_cnt <= 3'd0;
                                if (nrzi_bit && no_err) rcv_error <= ERR_STUFF;
                            end else begin
                                ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                                shreg    <= byte_next;
                                if (state == BODY) begin
                                    if (body_bits != 16'hFFFF) body_bits <= body_bits + 16'd1;
                                    // Two-byte delay line: a byte only becomes payload once
                                    // two newer bytes prove it is not part of the CRC16.
                                    if (byte_done) begin
                                        dly <= {byte_next, dly[15:8]};
                                        if (ptype == T_DATA && body_bytes >= 13'd2) begin
                                            if (pay_idx < 13'(MAX_DATA_BYTES)) begin
                                                for (int k = 0; k < MAX_DATA_BYTES; k++) begin
                                                    if (pay_idx == 13'(k)) rcv_data[8*k +: 8] <= dly[7:0];
                                                end
                                                rcv_byte_cnt <= BCW'(pay_idx + 13'd1);
                                            end else if (no_err) begin
                                                rcv_error <= ERR_OVFL;
                                            end
                                        end
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        if (state == SYNC) begin
                                            rcv_sync <= byte_next;
                                            if (byte_next != 8'h80 && no_err) rcv_error <= ERR_SYNC;
                                            state <= PID;
                                        end else begin
                                            rcv_pid <= byte_next;
                                            ptype   <= byte_next[1:0];
                                            if (no_err) begin
                                                if (byte_next[7:4] != ~byte_next[3:0])
                                                    rcv_error <= ERR_PID;
                                                else if (byte_next[1:0] == 2'b00)
                                                    rcv_error <= ERR_UNSUP;
                                            end
                                            state <= BODY;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                EOP: begin
                    if (sample && line_j) begin
                        state     <= HOLD;
                        pkt_valid <= 1'b1;
                        rcv_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
